// File: rtl/secuencia_pkg.sv
// Shared state encoding for the run-of-ones detector and its controller.
package secuencia_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    RUN  = 2'b10
  } state_t;

endpackage

// File: rtl/secuencia_tick_div.sv
// Sample-tick divider: one tick every SAMPLE_DIV enabled clk cycles, counter held at 0 while en=0.
module secuencia_tick_div #(
  parameter int SAMPLE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div_cnt_r;

  assign tick = en && (div_cnt_r == DIV_LAST);

  // Divider counter: wraps on tick, forced to zero while sampling is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
    end else if (!en || tick) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
    end
  end

endmodule

// File: rtl/secuencia_run_ctrl.sv
// Sampled "two-or-more consecutive 1s" detector with run-length records over valid/ready.
// Optional SEQ_RUN_TOTAL_EN adds a wrapping count of records loaded into the buffer.
module secuencia_run_ctrl
  import secuencia_pkg::*;
#(
  parameter int SAMPLE_DIV = 4,
  parameter int CNT_W      = 8,
  parameter int TOT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  output logic             det,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_len,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [TOT_W-1:0] evt_total
);

  localparam logic [CNT_W-1:0] LEN_MAX = '1;

  logic             tick_s;
  state_t           state_r;
  logic             det_r;
  logic [CNT_W-1:0] run_len_r;
  logic             evt_valid_r;
  logic [CNT_W-1:0] evt_len_r;
  logic             ovf_r;
  logic             fire_s;
  logic             drain_s;
  logic             load_s;

  secuencia_tick_div #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_div (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick_s)
  );

  // A run ends when a 0 is sampled in RUN; it loads if the buffer is empty or draining now.
  always_comb begin
    fire_s  = tick_s && (state_r == RUN) && !w;
    drain_s = evt_valid_r && evt_ready;
    load_s  = fire_s && (!evt_valid_r || evt_ready);
  end

  // Moore detector FSM, stepped only on sample ticks; det follows the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      det_r   <= 1'b0;
    end else if (tick_s) begin
      case (state_r)
        IDLE: begin
          state_r <= w ? ONE : IDLE;
          det_r   <= 1'b0;
        end
        ONE: begin
          state_r <= w ? RUN : IDLE;
          det_r   <= w;
        end
        RUN: begin
          state_r <= w ? RUN : IDLE;
          det_r   <= w;
        end
        default: begin
          state_r <= IDLE;
          det_r   <= 1'b0;
        end
      endcase
    end
  end

  // Run-length counter, saturating so very long runs report the maximum length.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_len_r <= '0;
    end else if (tick_s) begin
      if (!w) begin
        run_len_r <= '0;
      end else if (state_r == IDLE) begin
        run_len_r <= CNT_W'(1'b1);
      end else if (run_len_r != LEN_MAX) begin
        run_len_r <= run_len_r + CNT_W'(1'b1);
      end
    end
  end

  // Single-entry record buffer; evt_len only changes on a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid_r <= 1'b0;
      evt_len_r   <= '0;
    end else if (load_s) begin
      evt_valid_r <= 1'b1;
      evt_len_r   <= run_len_r;
    end else if (drain_s) begin
      evt_valid_r <= 1'b0;
    end
  end

  // Sticky drop flag; a drop in the same cycle wins over the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_r <= 1'b0;
    end else if (fire_s && !load_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

`ifdef SEQ_RUN_TOTAL_EN
  logic [TOT_W-1:0] total_r;

  // Count of records accepted into the buffer, wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_r <= '0;
    end else if (load_s) begin
      total_r <= total_r + TOT_W'(1'b1);
    end
  end

  assign evt_total = total_r;
`else
  assign evt_total = '0;
`endif

  assign det       = det_r;
  assign evt_valid = evt_valid_r;
  assign evt_len   = evt_len_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_secuencia_run_ctrl.sv
// Scoreboard bench for secuencia_run_ctrl: sample-level reference model, queued records, decoupled monitor.
module tb_secuencia_run_ctrl;

  localparam int SAMPLE_DIV = 4;
  localparam int CNT_W      = 8;
  localparam int TOT_W      = 16;
  localparam int LEN_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             w;
  logic             evt_ready;
  logic             ovf_clr;
  logic             det;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_len;
  logic             ovf;
  logic [TOT_W-1:0] evt_total;

  int checks = 0;
  int passes = 0;

  // reference model: sample phase, current run of 1s (unbounded), one-entry buffer
  int m_phase;
  int m_run;
  int m_total;
  bit m_valid;
  bit m_ovf;
  int exp_q[$];
  bit cur_w;

  always #5 clk = ~clk;

  secuencia_run_ctrl #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .CNT_W     (CNT_W),
    .TOT_W     (TOT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .w        (w),
    .det      (det),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_len  (evt_len),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .evt_total(evt_total)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_run   = 0;
    m_total = 0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  function automatic int exp_total();
`ifdef SEQ_RUN_TOTAL_EN
    return m_total;
`else
    return 0;
`endif
  endfunction

  // Advance the model across one posedge using the inputs currently applied.
  task automatic model_step();
    bit tick;
    bit fire;
    bit dropped;
    int rec;
    tick    = en && (m_phase == SAMPLE_DIV - 1);
    fire    = tick && !w && (m_run >= 2);
    dropped = fire && m_valid && !evt_ready;
    rec     = (m_run > LEN_MAX) ? LEN_MAX : m_run;
    if (!en) m_phase = 0;
    else m_phase = (m_phase + 1) % SAMPLE_DIV;
    if (tick) m_run = w ? m_run + 1 : 0;
    if (fire && !dropped) begin
      exp_q.push_back(rec);
      m_valid = 1'b1;
      m_total = (m_total + 1) % (1 << TOT_W);
    end else if (m_valid && evt_ready) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    check("det", det, (m_run >= 2) ? 1 : 0);
    check("evt_valid", evt_valid, m_valid);
    check("ovf", ovf, m_ovf);
    check("evt_total", evt_total, exp_total());
  endtask

  task automatic step(input bit wi, input bit ei, input bit ri, input bit ci);
    @(negedge clk);
    check_outputs();
    w = wi; en = ei; evt_ready = ri; ovf_clr = ci;
    model_step();
  endtask

  // One enabled sample period, so each call contains exactly one tick.
  task automatic sample(input bit wi, input bit ri);
    repeat (SAMPLE_DIV) step(wi, 1'b1, ri, 1'b0);
  endtask

  // Monitor: pop and compare a record on every handshake, just before the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (reset && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) check("unexpected_record", evt_len, -1);
        else check("evt_len", evt_len, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; w = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    cur_w = 1'b0;
    model_reset();
    #12;
    check("rst_det", det, 0);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_len", evt_len, 0);
    check("rst_ovf", ovf, 0);
    check("rst_evt_total", evt_total, 0);
    @(negedge clk);
    reset = 1'b1;

    // run of three samples, consumer always ready
    sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b1, 1'b1);
    sample(1'b0, 1'b1); sample(1'b0, 1'b1);

    // isolated 1 gives nothing, then 1,0,1,1,0 gives one record of 2
    sample(1'b1, 1'b1); sample(1'b0, 1'b1);
    sample(1'b1, 1'b1); sample(1'b0, 1'b1); sample(1'b1, 1'b1);
    sample(1'b1, 1'b1); sample(1'b0, 1'b1); sample(1'b0, 1'b1);

    // consumer stalled: second run dropped, ovf set, then cleared
    sample(1'b1, 1'b0); sample(1'b1, 1'b0); sample(1'b0, 1'b0);
    repeat (5) sample(1'b1, 1'b0);
    sample(1'b0, 1'b0); sample(1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);

    // enable dropped mid-run must not disturb the length
    sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b1, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0);
    sample(1'b1, 1'b1); sample(1'b1, 1'b1);
    sample(1'b0, 1'b1); sample(1'b0, 1'b1);

    // saturation of the run-length counter
    repeat (LEN_MAX + 20) sample(1'b1, 1'b1);
    sample(1'b0, 1'b1); sample(1'b0, 1'b1);

    // randomized traffic with frequent back-pressure and record/handshake collisions
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) cur_w = ~cur_w;
      step(cur_w, $urandom_range(0, 9) != 0, $urandom_range(0, 9) < 5,
           $urandom_range(0, 19) == 0);
    end

    // reset while a record is pending
    sample(1'b1, 1'b0); sample(1'b1, 1'b0); sample(1'b0, 1'b0);
    sample(1'b1, 1'b0); sample(1'b1, 1'b0);
    @(negedge clk);
    check_outputs();
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_det", det, 0);
    check("rst_mid_evt_valid", evt_valid, 0);
    check("rst_mid_evt_len", evt_len, 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_evt_total", evt_total, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    model_step();

    sample(1'b1, 1'b1); sample(1'b1, 1'b1); sample(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs();
    check("records_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
